adder_driver: RTL



---
 rtl/adder_driver_pkg.sv | 20 ++
 rtl/adder_driver_chk.sv | 68 ++++++
 rtl/adder_driver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/adder_driver_pkg.sv
// pa_adder: shared widths, reset value and driver state type for the
// adder_driver operand sequencer and its optional checker.
// Optional checker build is selected with ADDER_DRIVER_CHECK_EN.
package pa_adder;

  localparam int OP_W_DEF  = 4;
  localparam int RES_W_DEF = 7;
  localparam int CNT_W_DEF = 8;

  // Value the captured adder result takes while in reset.
  localparam int unsigned RV_C = 0;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } drv_state_t;

endpackage

// File: rtl/adder_driver_chk.sv
// adder_driver_chk: follows each issued beat through a 2-stage
// expected-sum pipeline, compares the adder result when it lands,
// keeps a saturating mismatch count and the most recent result.
// Instantiated only when ADDER_DRIVER_CHECK_EN is defined.
module adder_driver_chk
  import pa_adder::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             issue,
  input  logic [OP_W-1:0]  a_in,
  input  logic [OP_W-1:0]  b_in,
  input  logic [RES_W-1:0] c,
  output logic [CNT_W-1:0] err_cnt,
  output logic [RES_W-1:0] last_c
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [RES_W-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [RES_W-1:0] last_c_q, last_c_d;

  // Advance the expected pipeline and evaluate the compare for the beat two edges old.
  always_comb begin
    v1_d     = issue;
    exp1_d   = RES_W'(a_in) + RES_W'(b_in);
    v2_d     = v1_q;
    exp2_d   = exp1_q;
    err_d    = err_q;
    last_c_d = last_c_q;
    if (v2_q) begin
      last_c_d = c;
    end
    if (clr) begin
      err_d = '0;
    end else if (v2_q && (c != exp2_q) && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  // Pipeline, counter and capture registers; reset flushes any beats in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      exp1_q   <= '0;
      exp2_q   <= '0;
      err_q    <= '0;
      last_c_q <= RES_W'(RV_C);
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      exp1_q   <= exp1_d;
      exp2_q   <= exp2_d;
      err_q    <= err_d;
      last_c_q <= last_c_d;
    end
  end

  assign err_cnt = err_q;
  assign last_c  = last_c_q;

endmodule

// File: rtl/adder_driver.sv
// adder_driver: runs a programmed number of operand pairs into an adder,
// captures its registered result and reports done / error count.
// Define ADDER_DRIVER_CHECK_EN to build the result compare and err_cnt;
// without it err_cnt reads 0 and only last_c capture remains.
module adder_driver
  import pa_adder::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [OP_W-1:0]  a_seed,
  input  logic [OP_W-1:0]  b_seed,
  input  logic             hold,
  output logic [OP_W-1:0]  a,
  output logic [OP_W-1:0]  b,
  output logic             valid,
  input  logic [RES_W-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [RES_W-1:0] last_c
);

  drv_state_t       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             drain_q, drain_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             issue;

  // Next-state logic: the accepting edge issues beat 0 itself, so rem counts beats still to issue.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (num_ops == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            issue   = 1'b1;
            valid_d = 1'b1;
            a_d     = a_seed;
            b_d     = b_seed;
            rem_d   = num_ops - CNT_W'(1);
            drain_d = 1'b0;
            // A single-beat run has nothing left to drive and goes straight to draining.
            state_d = (num_ops == CNT_W'(1)) ? DRAIN : DRIVE;
          end
        end
      end
      DRIVE: begin
        if (!hold) begin
          issue   = 1'b1;
          valid_d = 1'b1;
          a_d     = a_q + OP_W'(1);
          b_d     = b_q - OP_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and all registered control/operand outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drain_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef ADDER_DRIVER_CHECK_EN
  logic err_clr;

  assign err_clr = (state_q == IDLE) && start && (num_ops != '0);

  adder_driver_chk #(
    .OP_W  (OP_W),
    .RES_W (RES_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .clr     (err_clr),
    .issue   (issue),
    .a_in    (a_d),
    .b_in    (b_d),
    .c       (c),
    .err_cnt (err_cnt),
    .last_c  (last_c)
  );
`else
  logic             cv1_q, cv2_q;
  logic [RES_W-1:0] last_c_q, last_c_d;

  // Without the checker, still take c two edges after each issued beat.
  always_comb begin
    last_c_d = cv2_q ? c : last_c_q;
  end

  // Beat-tracking pipeline and result capture register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cv1_q    <= 1'b0;
      cv2_q    <= 1'b0;
      last_c_q <= RES_W'(RV_C);
    end else begin
      cv1_q    <= issue;
      cv2_q    <= cv1_q;
      last_c_q <= last_c_d;
    end
  end

  assign last_c  = last_c_q;
  assign err_cnt = '0;
`endif

endmodule
